// File: rtl/svi_edge_window_counter.sv
// Counts rising edges of the asynchronous latch output y over fixed windows of i_clk cycles
// and publishes each window's count over valid/ready. Define SVI_EDGE_WINDOW_COUNTER_SYNC2_EN for a 2-flop synchronizer.
module svi_edge_window_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_en,
  input  logic             i_y,
  output logic             o_level,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow
);

  localparam int unsigned TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0]    TLAST = TW'(WINDOW - 1);
  localparam logic [WIDTH-1:0] CMAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sync1_q, sync1_d;
  logic             s_d_q, s_d_d;
  logic             s;

`ifdef SVI_EDGE_WINDOW_COUNTER_SYNC2_EN
  logic             sync2_q, sync2_d;
  assign s = sync2_q;
`else
  assign s = sync1_q;
`endif

  logic             rise;
  logic             acc_sat;
  logic             win_end;
  logic [WIDTH-1:0] report;

  assign rise    = s & ~s_d_q;
  assign acc_sat = (acc_q == CMAX);
  assign win_end = (state_q == RUN) && (timer_q == TLAST);
  // A rise in the terminal cycle still belongs to the closing window
  assign report  = (rise && !acc_sat) ? acc_q + WIDTH'(1) : acc_q;

  always_comb begin
    sync1_d = i_y;
`ifdef SVI_EDGE_WINDOW_COUNTER_SYNC2_EN
    sync2_d = sync1_q;
`endif
    s_d_d   = s;
    state_d = state_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        acc_d   = '0;
        if (i_en) state_d = RUN;
      end
      RUN: begin
        if (win_end) begin
          timer_d = '0;
          acc_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (rise && !acc_sat) acc_d = acc_q + WIDTH'(1);
        end
        // Dropping enable discards the partial window
        if (!i_en) begin
          state_d = IDLE;
          timer_d = '0;
          acc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Report publication: load when the slot is free or being drained, otherwise drop
    if (win_end) begin
      if (!valid_q || i_ready) begin
        count_d = report;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sync1_q <= 1'b0;
`ifdef SVI_EDGE_WINDOW_COUNTER_SYNC2_EN
      sync2_q <= 1'b0;
`endif
      s_d_q   <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
`ifdef SVI_EDGE_WINDOW_COUNTER_SYNC2_EN
      sync2_q <= sync2_d;
`endif
      s_d_q   <= s_d_d;
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_level    = s;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/svi_edge_window_counter.md
# svi_edge_window_counter

Downstream consumer of the `always_latch` output stage on the SVI port: it takes the latched scalar `y` as input and counts its rising edges over fixed windows of clock cycles. Each window's count is published through a valid/ready handshake for a monitor or register block. `y` is level-sensitive latch output, so the block treats it as asynchronous to `i_clk` and synchronizes it before edge detection.

## Interface
Parameters:
- `WIDTH`, default 8: width of the count and accumulator; legal range is ≥1.
- `WINDOW`, default 16: number of `i_clk` cycles per measurement window; legal range is ≥2.

Ports:
- `i_clk`, input, 1: the single clock.
- `i_arst`, input, 1: reset; asynchronous and active-high.
- `i_en`, input, 1: counting enable.
- `i_y`, input, 1: latched `y` from the latch stage, asynchronous to `i_clk`.
- `o_level`, output, 1: synchronized level of `i_y`.
- `o_valid`, output, 1: a report is pending.
- `i_ready`, input, 1: the consumer accepts the report.
- `o_count`, output, WIDTH: rising edges seen in the reported window.
- `o_overflow`, output, 1: sticky flag; a report was dropped.

## Operation
- **Input stage.** `i_y` passes through a synchronizer (see Configuration); its output is `s`, and `o_level = s`.
- **Edge detect.** `rise = s & ~s_d`, where `s_d` is `s` delayed by one register. Falling edges are not counted.
- **Accumulator `acc` (WIDTH bits).**
  - Increments on `rise` while in RUN.
  - Saturates at 2^WIDTH−1 and never wraps.
- **FSM, two states.**
  - IDLE: the window timer and `acc` are held at 0. Go to RUN when `i_en`=1.
  - RUN: the timer counts 0..WINDOW−1. Go to IDLE when `i_en`=0 at a clock edge; this clears the timer and `acc`, and the partial window is discarded.
- **Window end (RUN with timer = WINDOW−1).**
  - A report is formed as `acc + rise`, saturated.
  - `acc` and the timer both return to 0.
  - A rise in the terminal cycle belongs to the ending window.
- **Report handshake.**
  - A transfer occurs on any cycle with `o_valid` & `i_ready`.
  - `o_valid` and `o_count` stay stable until that transfer.
  - At window end with `o_valid`=0, or with `o_valid`=1 and `i_ready`=1: load `o_count` with the report and set `o_valid`=1. The second case gives back-to-back reports with no gap.
  - At window end with `o_valid`=1 and `i_ready`=0: drop the new report, keep `o_count` unchanged, and set `o_overflow`=1.
  - Transfer without a window end: clear `o_valid` at the next edge.
- **`o_overflow`** is cleared only by reset.
- **Leaving RUN.** A pending report survives the RUN→IDLE transition and is still delivered by the handshake.

## Timing
- Reset (`i_arst`=1) acts asynchronously and immediately, with no clock edge needed:
  - `o_level`=0, `o_valid`=0, `o_count`=0, `o_overflow`=0.
  - Synchronizer flops, `s_d`, `acc` and timer = 0; FSM = IDLE.
- A reset asserted mid-window or mid-handshake discards everything. Release is synchronous to the next `i_clk` rising edge.
- Latency from an `i_y` change to `o_level`:
  - 2 cycles with the macro defined.
  - 1 cycle without it.
- `rise` is seen in the first cycle `s`=1.
- The first window ends WINDOW cycles after the RUN entry edge. `o_valid` rises on the edge that closes the window.
- A rising edge is guaranteed to be counted only if `i_y` is held high and then low for at least 2 cycles each with the macro, or 1 cycle each without it. Shorter pulses may be missed.

## Configuration
- Macro: `SVI_EDGE_WINDOW_COUNTER_SYNC2_EN`.
- Defined: the synchronizer is two flops in series, giving a metastability-safe capture of the latch output.
- Undefined: the synchronizer is a single register, for benches and same-clock-domain use where `i_y` is known to change only on `i_clk` edges.
- Edge counting, windowing and the handshake are identical in both builds; only the `o_level`/`rise` latency differs, by one cycle.

## Test plan
All scenarios use WIDTH=8 and WINDOW=16 unless stated.

1. **Async reset mid-window.** Assert `i_arst` between clock edges in RUN with `acc`=5 and `o_valid`=1 → all outputs are 0 immediately. After release, the FSM is in IDLE and the first report comes 16 cycles after `i_en` is seen.
2. **Basic count.** Set `i_en`=1 and drive 3 pulses on `i_y` (2 cycles high, 2 low) within one window, with `i_ready`=0 → `o_valid`=1 at the window end with `o_count`=3. Then pulse `i_ready` → `o_valid`=0 on the next edge.
3. **Dropped report.** Keep `i_ready`=0 across 2 windows with 3 rises, then 5 rises → `o_count` stays 3 and `o_overflow`=1. Then assert `i_ready` → the transfer happens and `o_overflow` stays 1.
4. **Saturation.** WIDTH=2: toggle `i_y` every 2 cycles (4 rises per window) for one window → `o_count`=3, no wrap to 0. The next window starts from `acc`=0.
5. **Back-to-back reports.** Hold `i_ready`=1 permanently with 2 rises per window → a new `o_count`=2 at every window end, `o_valid` asserted 1 cycle per window, `o_overflow`=0.
6. **Latency and terminal edge.** With and without the macro: a rise on `i_y` appears on `o_level` after 2 cycles and 1 cycle respectively. A rise landing on timer=15 is counted in the ending window, and the next window starts at 0.
